cam_seq: RTL and testbench
==========================

Name: cam_seq

Overview:
Parametrised linear-CCD camera sequencer, the successor to the fixed-period SI pulse generator. It generates the SI (start-integration) pulse for one or more line cameras sharing cam_clk. It also produces a per-pixel valid strobe and index for the ADC capture path, frame start/done markers, and a runtime-extendable exposure. It supports continuous and single-shot modes and sits between the camera clock divider and the pixel capture logic.

Parameters:
N_CAM, 1, number of cameras driven; one SI output bit per camera.
N_PIX, 128, pixels read out per frame.
SI_WIDTH, 1, SI high time in cam_clk cycles (≥1).
FRAME_LEN, 156, base frame period in cycles; elaboration error unless FRAME_LEN ≥ SI_WIDTH + N_PIX + 1.
EXP_W, 8, width of the exposure-extension input.

Ports:
cam_clk  in  1  camera clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  run enable.
single  in  1  mode: 0 = continuous, 1 = single-shot.
start  in  1  single-shot trigger, sampled only in IDLE with single=1.
exp_ext  in  EXP_W  extra exposure cycles added to the frame period.
cam_en_mask  in  N_CAM  per-camera SI enable.
cam_si  out  N_CAM  SI pulse per camera.
pix_valid  out  1  high during each readout pixel cycle.
pix_idx  out  clog2(N_PIX)  current pixel index.
frame_start  out  1  1-cycle pulse, coincident with the first SI cycle.
frame_done  out  1  1-cycle pulse, cycle after the last pixel.
busy  out  1  high from the first SI cycle through the end of EXPOSE.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge): state IDLE, counters 0, cam_si=0, pix_valid=0, pix_idx=0, frame_start=0, frame_done=0, busy=0. This takes effect the next cycle regardless of the current state; a mid-frame reset truncates the frame.
- States: IDLE, SI_PH, READ, EXPOSE.
- IDLE -> SI_PH:
  - when en=1 and single=0; or
  - when en=1, single=1 and start=1.
  - The first SI cycle appears one cycle after the qualifying sample.
- Latching on the IDLE->SI_PH and EXPOSE->SI_PH transitions:
  - cam_en_mask -> mask_q; exp_ext -> ext_q.
  - Changes to either input mid-frame affect only the next frame.
- SI_PH: cam_si = mask_q for exactly SI_WIDTH cycles; frame_start on the first of them; busy=1. Then READ.
- READ:
  - N_PIX consecutive cycles with pix_valid=1.
  - pix_idx = 0..N_PIX-1, one per cycle; cam_si=0.
  - pix_idx holds N_PIX-1 after READ until the next READ begins; it resets to 0 only on rst.
- EXPOSE:
  - Lasts (FRAME_LEN − SI_WIDTH − N_PIX) + ext_q cycles, always ≥1.
  - frame_done pulses on its first cycle.
  - On the last cycle: if en=1 and single=0, go to SI_PH (back-to-back frames); otherwise go to IDLE with busy=0.
- Frame period (SI rising edge to SI rising edge) = FRAME_LEN + ext_q cycles, exactly.
- en deasserted mid-frame: the frame completes (readout never truncated), then IDLE.
- start while busy: ignored and not queued. start with single=0: ignored.
- single changed mid-frame: evaluated only at the end of EXPOSE.
- A frame with mask_q=0 still runs; cam_si stays 0, pix_valid/frame markers behave normally.
- Frame counter width: clog2(FRAME_LEN + 2^EXP_W); no wrap within a frame.

Decomposition:
- Package cam_seq_pkg:
  - state enum {IDLE, SI_PH, READ, EXPOSE};
  - width functions (PIX_W, CNT_W);
  - the FRAME_LEN legality check constant.
- Single module, no sub-module: one phase counter plus the FSM; pix_idx is derived from the READ-phase counter.

Test Plan:
1. Defaults, mask=1, single=0, en=1 after reset:
   - cam_si high 1 cycle, rising every 156 cycles;
   - pix_valid 128 cycles starting the cycle after SI, pix_idx 0..127;
   - frame_done 129 cycles after frame_start; busy continuously 1.
2. exp_ext=100:
   - period becomes 256;
   - changing exp_ext to 0 mid-READ keeps the current period at 256; the next period is 156.
3. single=1, one start pulse:
   - exactly one frame; busy high for 156 cycles, then 0;
   - a second start during busy yields no extra frame;
   - start after IDLE yields a new SI 1 cycle later.
4. en dropped at pix_idx=40:
   - readout continues to 127, frame_done pulses, EXPOSE finishes;
   - IDLE follows with no further SI.
5. rst asserted at pix_idx=60:
   - next cycle all outputs 0;
   - with en=1 held, SI reappears 1 cycle after rst deasserts.
6. N_CAM=2, SI_WIDTH=2, mask=2'b10:
   - only cam_si[1] pulses, high 2 cycles; READ still 128 cycles; period 156;
   - mask set to 2'b11 mid-frame applies from the next frame.

Source files
------------

// File: rtl/cam_seq_pkg.sv
// Shared types and elaboration-time helpers for the linear-CCD camera sequencer.
package cam_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSiPh,
        StRead,
        StExpose
    } state_e;

    function automatic int unsigned pix_w(input int unsigned n_pix);
        return (n_pix > 1) ? int'($clog2(n_pix)) : 1;
    endfunction

    // Phase counter must span the longest EXPOSE: base remainder plus the full extension range.
    function automatic int unsigned cnt_w(input int unsigned frame_len, input int unsigned exp_w);
        return int'($clog2(frame_len + (1 << exp_w)));
    endfunction

    function automatic bit frame_len_ok(input int unsigned frame_len,
                                        input int unsigned si_width,
                                        input int unsigned n_pix);
        return (si_width >= 1) && (frame_len >= si_width + n_pix + 1);
    endfunction

endpackage

// File: rtl/cam_seq.sv
// Line-camera sequencer: SI pulse, pixel readout strobe/index, frame markers and
// an exposure gap stretched at runtime by a per-frame latched extension.
module cam_seq
    import cam_seq_pkg::*;
#(
    parameter int unsigned N_CAM     = 1,
    parameter int unsigned N_PIX     = 128,
    parameter int unsigned SI_WIDTH  = 1,
    parameter int unsigned FRAME_LEN = 156,
    parameter int unsigned EXP_W     = 8,
    localparam int unsigned PIX_W    = pix_w(N_PIX)
) (
    input  logic             cam_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             single,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_ext,
    input  logic [N_CAM-1:0] cam_en_mask,
    output logic [N_CAM-1:0] cam_si,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_idx,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned CNT_W    = cnt_w(FRAME_LEN, EXP_W);
    localparam int unsigned EXP_BASE = FRAME_LEN - SI_WIDTH - N_PIX;

    if (!frame_len_ok(FRAME_LEN, SI_WIDTH, N_PIX)) begin : g_len_check
        $error("cam_seq: need SI_WIDTH >= 1 and FRAME_LEN >= SI_WIDTH + N_PIX + 1");
    end

    localparam logic [CNT_W-1:0] SiLast  = CNT_W'(SI_WIDTH - 1);
    localparam logic [CNT_W-1:0] PixLast = CNT_W'(N_PIX - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CAM-1:0]   mask_q, mask_d;
    logic [EXP_W-1:0]   ext_q, ext_d;
    logic [CNT_W-1:0]   exp_last;
    logic               launch;

    logic [N_CAM-1:0]   cam_si_q, cam_si_d;
    logic               pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]   pix_idx_q, pix_idx_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;

    assign exp_last = CNT_W'(EXP_BASE) + CNT_W'(ext_q) - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        ext_d   = ext_q;
        launch  = 1'b0;

        unique case (state_q)
            StIdle: launch = en && (!single || start);
            StSiPh: begin
                if (cnt_q == SiLast) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRead: begin
                if (cnt_q == PixLast) begin
                    state_d = StExpose;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StExpose: begin
                if (cnt_q == exp_last) begin
                    if (en && !single) begin
                        launch = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Mask and extension are frozen for the whole frame at its launch.
        if (launch) begin
            state_d = StSiPh;
            cnt_d   = '0;
            mask_d  = cam_en_mask;
            ext_d   = exp_ext;
        end

        // Outputs are decoded from the next state so they leave flops aligned with the phase.
        cam_si_d      = (state_d == StSiPh) ? mask_d : '0;
        frame_start_d = (state_d == StSiPh) && (cnt_d == '0);
        pix_valid_d   = (state_d == StRead);
        pix_idx_d     = pix_valid_d ? cnt_d[PIX_W-1:0] : pix_idx_q;
        frame_done_d  = (state_d == StExpose) && (cnt_d == '0);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge cam_clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mask_q        <= '0;
            ext_q         <= '0;
            cam_si_q      <= '0;
            pix_valid_q   <= 1'b0;
            pix_idx_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            ext_q         <= ext_d;
            cam_si_q      <= cam_si_d;
            pix_valid_q   <= pix_valid_d;
            pix_idx_q     <= pix_idx_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign cam_si      = cam_si_q;
    assign pix_valid   = pix_valid_q;
    assign pix_idx     = pix_idx_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cam_seq.sv
// Bench for cam_seq: two instances (1 camera / SI 1 cycle, 2 cameras / SI 2 cycles) against a
// frame-time reference model, plus a directed vector table and single-shot/en/reset sequences.
module tb_cam_seq;

    localparam int N_PIX     = 128;
    localparam int FRAME_LEN = 156;

    logic       cam_clk;
    logic       rst;
    logic       en;
    logic       single;
    logic       start;
    logic [7:0] exp_ext;
    logic [0:0] mask0;
    logic [1:0] mask1;

    logic [0:0] si0;
    logic       pv0, fs0, fd0, busy0;
    logic [6:0] idx0;
    logic [1:0] si1;
    logic       pv1, fs1, fd1, busy1;
    logic [6:0] idx1;

    cam_seq #(
        .N_CAM(1), .N_PIX(N_PIX), .SI_WIDTH(1), .FRAME_LEN(FRAME_LEN), .EXP_W(8)
    ) u_dut0 (
        .cam_clk(cam_clk), .rst(rst), .en(en), .single(single), .start(start),
        .exp_ext(exp_ext), .cam_en_mask(mask0), .cam_si(si0), .pix_valid(pv0),
        .pix_idx(idx0), .frame_start(fs0), .frame_done(fd0), .busy(busy0)
    );

    cam_seq #(
        .N_CAM(2), .N_PIX(N_PIX), .SI_WIDTH(2), .FRAME_LEN(FRAME_LEN), .EXP_W(8)
    ) u_dut1 (
        .cam_clk(cam_clk), .rst(rst), .en(en), .single(single), .start(start),
        .exp_ext(exp_ext), .cam_en_mask(mask1), .cam_si(si1), .pix_valid(pv1),
        .pix_idx(idx1), .frame_start(fs1), .frame_done(fd1), .busy(busy1)
    );

    initial cam_clk = 1'b0;
    always #5 cam_clk = ~cam_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    logic [12:0] o0, o1;
    assign o0 = {1'b0, si0, pv0, idx0, fs0, fd0, busy0};
    assign o1 = {si1, pv1, idx1, fs1, fd1, busy1};

    function automatic logic [12:0] pk(int si, int pv, int idx, int fs, int fd, int bsy);
        return {2'(si), 1'(pv), 7'(idx), 1'(fs), 1'(fd), 1'(bsy)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cam_clk);
        #1;
        cyc++;
    endtask

    // Reference model: each frame is a timeline of FRAME_LEN+ext cycles measured from SI rise.
    bit m_act  [2] = '{1'b0, 1'b0};
    int m_t    [2] = '{0, 0};
    int m_ext  [2] = '{0, 0};
    int m_mask [2] = '{0, 0};
    int m_last [2] = '{0, 0};

    function automatic int si_w(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic begin_frame(int i);
        m_act[i]  = 1'b1;
        m_t[i]    = 0;
        m_ext[i]  = int'(exp_ext);
        m_mask[i] = (i == 0) ? int'(mask0) : int'(mask1);
    endtask

    always @(posedge cam_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i]  = 1'b0;
                m_last[i] = 0;
            end else if (!m_act[i]) begin
                if (en && (!single || start)) begin_frame(i);
            end else begin
                m_t[i]++;
                if (m_t[i] == FRAME_LEN + m_ext[i]) begin
                    if (en && !single) begin_frame(i);
                    else m_act[i] = 1'b0;
                end
            end
            if (m_act[i] && m_t[i] >= si_w(i) && m_t[i] < si_w(i) + N_PIX)
                m_last[i] = m_t[i] - si_w(i);
        end
    end

    function automatic logic [12:0] model_out(int i);
        int si = 0, pv = 0, fs = 0, fd = 0, bsy = 0;
        if (m_act[i]) begin
            bsy = 1;
            if (m_t[i] < si_w(i)) begin
                si = m_mask[i];
                fs = (m_t[i] == 0) ? 1 : 0;
            end else if (m_t[i] < si_w(i) + N_PIX) begin
                pv = 1;
            end else if (m_t[i] == si_w(i) + N_PIX) begin
                fd = 1;
            end
        end
        return pk(si, pv, m_last[i], fs, fd, bsy);
    endfunction

    always @(negedge cam_clk) begin
        if (chk_on) begin
            chk("model0", 32'(o0), 32'(model_out(0)));
            chk("model1", 32'(o1), 32'(model_out(1)));
        end
    end

    typedef struct {
        int          cyc;
        int          en;
        int          ext;
        int          m1;
        logic [12:0] e0;
        logic [12:0] e1;
    } vec_t;

    vec_t tv[$];

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_pix(int target, string name);
        int n = 0;
        while (!(pv0 && idx0 == 7'(target)) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: timeout waiting for pix_idx=%0d", name, target);
        end
    endtask

    initial begin
        int n, pvc, fdc, fsc;
        rst = 1'b1; en = 1'b1; single = 1'b0; start = 1'b0;
        exp_ext = 8'd0; mask0 = 1'b1; mask1 = 2'b10;

        // Inputs in each record are applied right after that record's sample.
        tv.push_back('{1,   1, 0,   2, pk(1,0,0,1,0,1),   pk(2,0,0,1,0,1)});
        tv.push_back('{2,   1, 0,   2, pk(0,1,0,0,0,1),   pk(2,0,0,0,0,1)});
        tv.push_back('{3,   1, 0,   2, pk(0,1,1,0,0,1),   pk(0,1,0,0,0,1)});
        tv.push_back('{50,  1, 100, 3, pk(0,1,48,0,0,1),  pk(0,1,47,0,0,1)});
        tv.push_back('{129, 1, 100, 3, pk(0,1,127,0,0,1), pk(0,1,126,0,0,1)});
        tv.push_back('{130, 1, 100, 3, pk(0,0,127,0,1,1), pk(0,1,127,0,0,1)});
        tv.push_back('{131, 1, 100, 3, pk(0,0,127,0,0,1), pk(0,0,127,0,1,1)});
        tv.push_back('{156, 1, 100, 3, pk(0,0,127,0,0,1), pk(0,0,127,0,0,1)});
        tv.push_back('{157, 1, 100, 3, pk(1,0,127,1,0,1), pk(3,0,127,1,0,1)});
        tv.push_back('{158, 1, 0,   3, pk(0,1,0,0,0,1),   pk(3,0,127,0,0,1)});
        tv.push_back('{412, 1, 0,   3, pk(0,0,127,0,0,1), pk(0,0,127,0,0,1)});
        tv.push_back('{413, 1, 0,   3, pk(1,0,127,1,0,1), pk(3,0,127,1,0,1)});
        tv.push_back('{569, 0, 0,   3, pk(1,0,127,1,0,1), pk(3,0,127,1,0,1)});
        tv.push_back('{725, 0, 0,   3, pk(0,0,127,0,0,0), pk(0,0,127,0,0,0)});
        tv.push_back('{800, 0, 0,   3, pk(0,0,127,0,0,0), pk(0,0,127,0,0,0)});

        step();
        chk_on = 1'b1;
        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            while (cyc < tv[i].cyc) step();
            chk($sformatf("tbl0[%0d]", tv[i].cyc), 32'(o0), 32'(tv[i].e0));
            chk($sformatf("tbl1[%0d]", tv[i].cyc), 32'(o1), 32'(tv[i].e1));
            en      = 1'(tv[i].en);
            exp_ext = 8'(tv[i].ext);
            mask1   = 2'(tv[i].m1);
        end

        // Single-shot: one frame per start, start during busy is dropped.
        single = 1'b1; en = 1'b1; mask0 = 1'b1;
        do_reset();
        repeat (5) step();
        chk("single_idle_busy", 32'(busy0), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("single_si", 32'(si0), 32'd1);
        n = 0;
        for (int k = 0; k < 1000 && busy0; k++) begin
            n++;
            step();
            start = (n == 50);
        end
        start = 1'b0;
        chk("single_busy_len", 32'(n), 32'd156);
        fsc = 0;
        repeat (300) begin
            step();
            if (fs0) fsc++;
        end
        chk("single_no_queue", 32'(fsc), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("single_restart_si", 32'(si0), 32'd1);
        repeat (200) step();

        // en dropped mid-readout: frame runs to completion, then idle.
        single = 1'b0; en = 1'b1;
        do_reset();
        wait_pix(40, "en_drop_wait");
        en = 1'b0;
        pvc = 0; fdc = 0; fsc = 0;
        repeat (400) begin
            step();
            if (pv0) pvc++;
            if (fd0) fdc++;
            if (fs0) fsc++;
        end
        chk("en_drop_pix", 32'(pvc), 32'd87);
        chk("en_drop_done", 32'(fdc), 32'd1);
        chk("en_drop_no_si", 32'(fsc), 32'd0);
        chk("en_drop_idle", 32'(busy0), 32'd0);

        // Mid-frame reset truncates; SI resumes one cycle after release.
        en = 1'b1;
        wait_pix(60, "rst_wait");
        rst = 1'b1;
        step();
        chk("rst_zero0", 32'(o0), 32'd0);
        chk("rst_zero1", 32'(o1), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_resume_si", 32'(si0), 32'd1);
        chk("rst_resume_fs", 32'(fs1), 32'd1);

        // Randomized traffic, checked every cycle by the model.
        for (int k = 0; k < 8000; k++) begin
            step();
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 499) == 0) single = ~single;
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0)
                exp_ext = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 20));
            if ($urandom_range(0, 49) == 0) begin
                mask0 = 1'($urandom);
                mask1 = 2'($urandom);
            end
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
